// File: rtl/fan_speed_sequencer.sv
// Fan PWM sequencer: accepts speed-level requests and a shut-off timer,
// soft-ramps the PWM duty one step per PWM period toward the level's target.
module fan_speed_sequencer #(
    parameter int unsigned CLK_HZ    = 1000,
    parameter int unsigned PWM_DIV   = 1,
    parameter int unsigned RAMP_STEP = 5,
    parameter int unsigned LOW_DUTY  = 40,
    parameter int unsigned MID_DUTY  = 70,
    parameter int unsigned HIGH_DUTY = 100,
    parameter int unsigned TIMER_W   = 16
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [1:0]         speed_req,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TIMER_W-1:0] timer_load,
    input  logic               timer_valid,
    output logic               pwm_out,
    output logic [6:0]         duty_cur,
    output logic [1:0]         state,
    output logic [TIMER_W-1:0] timer_remain,
    output logic               done
);

    localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned SEC_W = $clog2(CLK_HZ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t             st, st_n;
    logic [DIV_W-1:0]   div_cnt;
    logic [6:0]         pwm_cnt;
    logic [SEC_W-1:0]   sec_cnt;
    logic               pwm_step, period_tick, sec_tick;
    logic               expire_now, accept;
    logic [6:0]         target, target_n, duty_n, req_target;
    logic               stopping, stopping_n, done_n;
    logic [TIMER_W-1:0] timer_n;
    logic [7:0]         up_sum, dn_floor;

    assign pwm_step    = (div_cnt == DIV_W'(PWM_DIV - 1));
    assign period_tick = pwm_step && (pwm_cnt == 7'd99);
    assign sec_tick    = (sec_cnt == SEC_W'(CLK_HZ - 1));
    assign expire_now  = sec_tick && (timer_remain == TIMER_W'(1)) && (st != IDLE);
    assign req_ready   = !stopping && !expire_now;
    assign accept      = req_valid && req_ready;
    assign state       = st;

    always_comb begin
        case (speed_req)
            2'd1:    req_target = 7'(LOW_DUTY);
            2'd2:    req_target = 7'(MID_DUTY);
            2'd3:    req_target = 7'(HIGH_DUTY);
            default: req_target = '0;
        endcase
    end

    // 8-bit intermediates so the clamp comparisons cannot wrap.
    assign up_sum   = {1'b0, duty_cur} + 8'(RAMP_STEP);
    assign dn_floor = {1'b0, target} + 8'(RAMP_STEP);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
            sec_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (pwm_step) begin
                div_cnt <= '0;
                pwm_cnt <= (pwm_cnt == 7'd99) ? '0 : pwm_cnt + 7'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            sec_cnt <= sec_tick ? '0 : sec_cnt + 1'b1;
            pwm_out <= (pwm_cnt < duty_cur);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            duty_cur     <= '0;
            target       <= '0;
            stopping     <= 1'b0;
            timer_remain <= '0;
            done         <= 1'b0;
        end else begin
            st           <= st_n;
            duty_cur     <= duty_n;
            target       <= target_n;
            stopping     <= stopping_n;
            timer_remain <= timer_n;
            done         <= done_n;
        end
    end

    // Priority: expiry, then an accepted request, then the per-period ramp step.
    always_comb begin
        st_n       = st;
        target_n   = target;
        duty_n     = duty_cur;
        stopping_n = stopping;
        done_n     = 1'b0;
        timer_n    = timer_remain;

        if (expire_now) begin
            target_n   = '0;
            stopping_n = 1'b1;
            st_n       = RAMP_DOWN;
        end else if (accept) begin
            if (st == IDLE) begin
                if (speed_req != 2'd0) begin
                    target_n = req_target;
                    st_n     = RAMP_UP;
                end
            end else begin
                target_n = req_target;
                if (req_target > duty_cur)      st_n = RAMP_UP;
                else if (req_target < duty_cur) st_n = RAMP_DOWN;
                else                            st_n = RUN;
            end
        end else if (period_tick) begin
            case (st)
                RAMP_UP: begin
                    duty_n = (up_sum >= {1'b0, target}) ? target : up_sum[6:0];
                    if (duty_n == target) st_n = RUN;
                end
                RAMP_DOWN: begin
                    duty_n = ({1'b0, duty_cur} <= dn_floor) ? target : duty_cur - 7'(RAMP_STEP);
                    if (duty_n == target) begin
                        if (target == '0) begin
                            st_n   = IDLE;
                            done_n = 1'b1;
                        end else begin
                            st_n = RUN;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Entering IDLE discards any timer value, including one loaded while stopping.
        if (st_n == IDLE && st != IDLE) begin
            stopping_n = 1'b0;
            timer_n    = '0;
        end else if (timer_valid) begin
            timer_n = timer_load;
        end else if (sec_tick && st != IDLE && timer_remain != '0) begin
            timer_n = timer_remain - 1'b1;
        end
    end

endmodule
